// File: rtl/cmd_stream_fetch.sv
// cmd_stream_fetch
//   Command-fetch stage that sits directly after the command-stream BRAM.
//   Starting at base_addr, it walks stream_len 32-bit command words.
//   Each header word is decoded and issued on the command channel.
//   The header's operands are then issued on the argument channel in beats
//   of up to four words.
//
//   Header word layout:
//     [31]    has_args -- [15:8] is an operand count, otherwise an immediate
//     [15:8]  operand count / immediate
//     [7:0]   opcode
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: begin a stream (ignored while busy)
//   abort                 synchronous: drop everything and return to IDLE
//   base_addr, stream_len first word address and length (words)
//   mem_addr1 / mem_rd0   header read port (combinational data)
//   mem_addr2 / mem_rd1-4 four-word burst port, words at mem_addr2+0..+3
//   cmd_valid/ready       command channel
//     cmd_opcode, cmd_field, cmd_has_args
//   arg_valid/ready       argument channel
//     arg_data            lane 0 in [31:0], unused lanes zero
//     arg_count           valid words in the beat, 1..4
//     arg_last            final beat of the command
//   busy, done, err       status; done and err are one-cycle pulses
//
// Optional feature: define CMD_STREAM_FETCH_PERF_EN to add the
//   perf_cmds and perf_stalls counters and their output ports.

module cmd_stream_fetch #(
  parameter int ADDR_W   = 32,
  parameter int MAX_ARGS = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stream_len,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  input  logic [31:0]       mem_rd0,
  input  logic [31:0]       mem_rd1,
  input  logic [31:0]       mem_rd2,
  input  logic [31:0]       mem_rd3,
  input  logic [31:0]       mem_rd4,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [7:0]        cmd_opcode,
  output logic [7:0]        cmd_field,
  output logic              cmd_has_args,
  output logic              arg_valid,
  input  logic              arg_ready,
  output logic [127:0]      arg_data,
  output logic [2:0]        arg_count,
  output logic              arg_last,
`ifdef CMD_STREAM_FETCH_PERF_EN
  output logic [31:0]       perf_cmds,
  output logic [31:0]       perf_stalls,
`endif
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    CMD  = 3'd2,
    ARGF = 3'd3,
    ARGO = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] remaining_reg, remaining_next;
  logic [ADDR_W-1:0] args_left_reg, args_left_next;
  logic              cmd_valid_reg, cmd_valid_next;
  logic [7:0]        opcode_reg, opcode_next;
  logic [7:0]        field_reg, field_next;
  logic              has_args_reg, has_args_next;
  logic              arg_valid_reg, arg_valid_next;
  logic [127:0]      arg_data_reg, arg_data_next;
  logic [2:0]        arg_count_reg, arg_count_next;
  logic              arg_last_reg, arg_last_next;
  logic              err_reg, err_next;

  // Header decode and per-beat helpers.
  logic [ADDR_W-1:0] hdr_args;
  logic [ADDR_W-1:0] rem_dec;
  logic [2:0]        beat_n;
  logic [ADDR_W-1:0] beat_ext;
  logic [31:0]       burst [4];
  logic [127:0]      beat_data;
  state_t            after_xfer;
  logic              unused_hdr_bits;

  assign hdr_args = mem_rd0[31] ? {{(ADDR_W-8){1'b0}}, mem_rd0[15:8]} : '0;
  assign rem_dec  = remaining_reg - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign beat_n   = (args_left_reg >= ADDR_W'(4)) ? 3'd4 : args_left_reg[2:0];
  assign beat_ext = {{(ADDR_W-3){1'b0}}, beat_n};

  // Header bits [30:16] carry no meaning for this stage.
  assign unused_hdr_bits = ^mem_rd0[30:16];

  assign burst[0] = mem_rd1;
  assign burst[1] = mem_rd2;
  assign burst[2] = mem_rd3;
  assign burst[3] = mem_rd4;

  // Lanes past the operand count are zeroed so the consumer never sees
  // words belonging to the next header.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign beat_data[32*gi +: 32] = (3'(gi) < beat_n) ? burst[gi] : 32'd0;
    end
  endgenerate

  // Where to go once a command or argument beat has been accepted.
  always_comb begin
    after_xfer = HDR;
    if (args_left_reg != '0) begin
      after_xfer = ARGF;
    end else if (remaining_reg == '0) begin
      after_xfer = DONE;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    args_left_next = args_left_reg;
    cmd_valid_next = cmd_valid_reg;
    opcode_next    = opcode_reg;
    field_next     = field_reg;
    has_args_next  = has_args_reg;
    arg_valid_next = arg_valid_reg;
    arg_data_next  = arg_data_reg;
    arg_count_next = arg_count_reg;
    arg_last_next  = arg_last_reg;
    err_next       = 1'b0;

    if (abort) begin
      // Abort outranks every transition, including a same-cycle start.
      state_next     = IDLE;
      cmd_valid_next = 1'b0;
      arg_valid_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (stream_len == '0) begin
              state_next = DONE;
            end else begin
              ptr_next       = base_addr;
              remaining_next = stream_len;
              state_next     = HDR;
            end
          end
        end

        HDR: begin
          opcode_next    = mem_rd0[7:0];
          field_next     = mem_rd0[15:8];
          has_args_next  = mem_rd0[31];
          args_left_next = hdr_args;
          ptr_next       = ptr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
          remaining_next = rem_dec;
          // Operands must fit in what is left of the stream after the header.
          if ((hdr_args > rem_dec) || (hdr_args > ADDR_W'(MAX_ARGS))) begin
            err_next   = 1'b1;
            state_next = IDLE;
          end else begin
            cmd_valid_next = 1'b1;
            state_next     = CMD;
          end
        end

        CMD: begin
          if (cmd_ready) begin
            cmd_valid_next = 1'b0;
            state_next     = after_xfer;
          end
        end

        ARGF: begin
          arg_data_next  = beat_data;
          arg_count_next = beat_n;
          arg_last_next  = (args_left_reg <= ADDR_W'(4));
          arg_valid_next = 1'b1;
          ptr_next       = ptr_reg + beat_ext;
          remaining_next = remaining_reg - beat_ext;
          args_left_next = args_left_reg - beat_ext;
          state_next     = ARGO;
        end

        ARGO: begin
          if (arg_ready) begin
            arg_valid_next = 1'b0;
            state_next     = after_xfer;
          end
        end

        DONE: begin
          state_next = IDLE;
        end

        default: begin
          state_next     = IDLE;
          cmd_valid_next = 1'b0;
          arg_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      args_left_reg <= '0;
      cmd_valid_reg <= 1'b0;
      opcode_reg    <= '0;
      field_reg     <= '0;
      has_args_reg  <= 1'b0;
      arg_valid_reg <= 1'b0;
      arg_data_reg  <= '0;
      arg_count_reg <= '0;
      arg_last_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      args_left_reg <= args_left_next;
      cmd_valid_reg <= cmd_valid_next;
      opcode_reg    <= opcode_next;
      field_reg     <= field_next;
      has_args_reg  <= has_args_next;
      arg_valid_reg <= arg_valid_next;
      arg_data_reg  <= arg_data_next;
      arg_count_reg <= arg_count_next;
      arg_last_reg  <= arg_last_next;
      err_reg       <= err_next;
    end
  end

  // Both BRAM ports track the single walk pointer.
  assign mem_addr1    = ptr_reg;
  assign mem_addr2    = ptr_reg;
  assign cmd_valid    = cmd_valid_reg;
  assign cmd_opcode   = opcode_reg;
  assign cmd_field    = field_reg;
  assign cmd_has_args = has_args_reg;
  assign arg_valid    = arg_valid_reg;
  assign arg_data     = arg_data_reg;
  assign arg_count    = arg_count_reg;
  assign arg_last     = arg_last_reg;
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign err          = err_reg;

`ifdef CMD_STREAM_FETCH_PERF_EN
  logic [31:0] perf_cmds_reg;
  logic [31:0] perf_stalls_reg;
  logic        perf_clear;
  logic        stall_cycle;

  assign perf_clear  = start && (state_reg == IDLE) && !abort;
  assign stall_cycle = (cmd_valid_reg && !cmd_ready) || (arg_valid_reg && !arg_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cmds_reg   <= '0;
      perf_stalls_reg <= '0;
    end else if (perf_clear) begin
      perf_cmds_reg   <= '0;
      perf_stalls_reg <= '0;
    end else begin
      if (cmd_valid_reg && cmd_ready && (perf_cmds_reg != 32'hFFFF_FFFF)) begin
        perf_cmds_reg <= perf_cmds_reg + 32'd1;
      end
      if (stall_cycle && (perf_stalls_reg != 32'hFFFF_FFFF)) begin
        perf_stalls_reg <= perf_stalls_reg + 32'd1;
      end
    end
  end

  assign perf_cmds   = perf_cmds_reg;
  assign perf_stalls = perf_stalls_reg;
`endif

endmodule
